// File: rtl/sc1_uart_proto.sv
// sc1_uart_proto: shared constants and types for the SoC UART word protocol.
// Both the word transmitter and the SoC loader use this package, so they
// agree on the frame markers, the frame length and the bit-engine states.
// No ports (package only).
package sc1_uart_proto;

  localparam logic [7:0] UART_START_BYTE    = 8'haa;
  localparam logic [7:0] UART_END_BYTE      = 8'h55;
  localparam int         UART_FRAME_BYTES   = 10;
  localparam int         UART_BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Returns the byte sent at position idx of a frame:
  // start marker, address little-endian, data little-endian, end marker.
  function automatic logic [7:0] frame_byte(input logic [31:0] addr,
                                            input logic [31:0] data,
                                            input logic [3:0]  idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = UART_START_BYTE;
      4'd1:    b = addr[7:0];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[23:16];
      4'd4:    b = addr[31:24];
      4'd5:    b = data[7:0];
      4'd6:    b = data[15:8];
      4'd7:    b = data[23:16];
      4'd8:    b = data[31:24];
      default: b = UART_END_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 bit engine for one byte (START / DATA / STOP).
// A new byte can be loaded in IDLE or in the last cycle of a stop bit, which
// lets consecutive bytes run with no gap between them.
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   byte_valid   a byte is offered on byte_in
//   byte_ready   engine takes byte_in on this edge if byte_valid
//   byte_in      byte to send, LSB first
//   txd          registered serial line, idle high
//   busy         engine is not IDLE
module uart_byte_tx
  import sc1_uart_proto::*;
#(
  parameter int BIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] byte_in,
  output logic       txd,
  output logic       busy
);

  localparam int WAIT = BIT_CYCLES - 1;
  localparam int TICK_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] WAIT_T = TICK_W'(WAIT);
  localparam logic [2:0] LAST_BIT = 3'(UART_BITS_PER_BYTE - 1);

  uart_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_q;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        cur_byte_q;
  logic              txd_q, txd_d;
  logic              tick_end;
  logic              load;

  assign tick_end   = (tick_q == WAIT_T);
  assign byte_ready = (state_q == IDLE) || ((state_q == STOP) && tick_end);
  assign load       = byte_valid && byte_ready;
  assign txd        = txd_q;

  // State register. The tick counter restarts at every bit boundary and is
  // parked at 0 in IDLE; with one cycle per bit it therefore never leaves 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      cur_byte_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      if (load) begin
        cur_byte_q <= byte_in;
      end
      if ((state_q == IDLE) || tick_end) begin
        tick_q <= '0;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  // Next-state logic. bit_idx is cleared on entering DATA and holds at 7
  // through STOP, so it never wraps.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (byte_valid) state_d = START;
      end
      START: begin
        if (tick_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick_end) begin
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (tick_end) state_d = byte_valid ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The line value is computed from the next state so that the
  // registered txd lines up with the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    busy  = (state_q != IDLE);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte_q[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends one (address, data) pair as a 10-byte 8N1 frame:
// 0xAA, address LE, data LE, 0x55.
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   in_valid/in_ready   word handshake; transfer when both high on posedge
//   in_address, in_data word captured at the accepting edge
//   uart_txd            serial output, idle high
//   busy                frame in progress
//   done                one-cycle pulse after the final stop bit
module uart_word_tx
  import sc1_uart_proto::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCLK_HZ = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  output logic        uart_txd,
  output logic        busy,
  output logic        done
);

  localparam int BIT_CYCLES = CLK_HZ / SCLK_HZ;
  localparam logic [3:0] LAST_BYTE = 4'(UART_FRAME_BYTES - 1);

  if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
    $error("uart_word_tx: CLK_HZ/SCLK_HZ must be at least 1");
  end

  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  byte_idx_q;
  logic        done_q;
  logic        eng_busy;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_in;
  logic        accept;
  logic        advance;
  logic        frame_end;

  assign in_ready = !eng_busy;
  assign busy     = eng_busy;
  assign done     = done_q;
  assign accept   = in_valid && in_ready;

  // While idle the offered word starts a frame with the start marker; during
  // a frame the engine is fed the byte after the one currently on the line.
  assign byte_valid = eng_busy ? (byte_idx_q < LAST_BYTE) : in_valid;
  assign byte_in    = eng_busy ? frame_byte(addr_q, data_q, byte_idx_q + 4'd1)
                               : UART_START_BYTE;
  assign advance    = eng_busy && byte_ready && byte_valid;
  assign frame_end  = eng_busy && byte_ready && (byte_idx_q == LAST_BYTE);

  // Word capture, byte index and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (accept) begin
        addr_q     <= in_address;
        data_q     <= in_data;
        byte_idx_q <= '0;
      end else if (advance) begin
        byte_idx_q <= byte_idx_q + 4'd1;
      end
    end
  end

  uart_byte_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_in   (byte_in),
    .txd       (uart_txd),
    .busy      (eng_busy)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench for uart_word_tx at the default bit rate
// (two clocks per bit) and at one clock per bit.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, uart_txd, busy, done;
  logic [31:0] in_address, in_data;
  logic        in_valid1, in_ready1, uart_txd1, busy1, done1;
  logic [31:0] in_address1, in_data1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_word_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_address(in_address),
    .in_data   (in_data),
    .uart_txd  (uart_txd),
    .busy      (busy),
    .done      (done)
  );

  uart_word_tx #(
    .CLK_HZ (25_000_000),
    .SCLK_HZ(25_000_000)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_address(in_address1),
    .in_data   (in_data1),
    .uart_txd  (uart_txd1),
    .busy      (busy1),
    .done      (done1)
  );

  function automatic logic txdOf(input bit sel);
    return sel ? uart_txd1 : uart_txd;
  endfunction

  function automatic logic readyOf(input bit sel);
    return sel ? in_ready1 : in_ready;
  endfunction

  function automatic logic doneOf(input bit sel);
    return sel ? done1 : done;
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offers a word and returns #1 after the accepting edge; in_valid is left
  // high so the caller decides what to offer next.
  task automatic offerWord(input bit sel, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
    bit ok = 1'b0;
    if (sel) begin
      in_valid1 = 1'b1; in_address1 = a; in_data1 = d;
    end else begin
      in_valid = 1'b1; in_address = a; in_data = d;
    end
    for (int i = 0; i < 50; i++) begin
      if (readyOf(sel) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkEq({tag, " accept"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Samples every cycle of a frame starting the cycle after acceptance and
  // checks each byte, bit lengths, in_ready low, no early done, then the done
  // cycle. With scramble set the word inputs and in_valid are disturbed.
  task automatic checkFrame(input bit sel, input int bc, input logic [79:0] expf,
                            input string tag, input bit scramble);
    bit stable = 1'b1, readyLow = 1'b1, doneLow = 1'b1;
    for (int b = 0; b < 10; b++) begin
      logic [7:0] eb;
      logic [9:0] want, got;
      eb   = expf[79-8*b -: 8];
      want = {1'b1, eb, 1'b0};
      got  = '0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < bc; c++) begin
          logic v;
          @(negedge clk);
          v = txdOf(sel);
          if (c == 0) got[k] = v;
          else if (v !== got[k]) stable = 1'b0;
          if (readyOf(sel) !== 1'b0) readyLow = 1'b0;
          if (doneOf(sel) !== 1'b0) doneLow = 1'b0;
          if (scramble) begin
            in_address = $urandom;
            in_data    = $urandom;
            in_valid   = (b == 9 && k == 9 && c == bc - 1) ? 1'b0 : ~in_valid;
          end
        end
      end
      checkEq($sformatf("%s byte%0d", tag, b), 64'(got), 64'(want));
    end
    checkEq({tag, " bit length"}, 64'(stable), 64'd1);
    checkEq({tag, " in_ready low"}, 64'(readyLow), 64'd1);
    checkEq({tag, " no early done"}, 64'(doneLow), 64'd1);
    @(negedge clk);
    checkEq({tag, " done pulse"}, 64'(doneOf(sel)), 64'd1);
    checkEq({tag, " in_ready back"}, 64'(readyOf(sel)), 64'd1);
    checkEq({tag, " idle line"}, 64'(txdOf(sel)), 64'd1);
  endtask

  initial begin
    bit doneSeen;
    rst_n = 1'b0;
    in_valid = 1'b0;  in_address = '0;  in_data = '0;
    in_valid1 = 1'b0; in_address1 = '0; in_data1 = '0;

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    checkEq("rst txd", 64'(uart_txd), 64'd1);
    checkEq("rst in_ready", 64'(in_ready), 64'd1);
    checkEq("rst busy", 64'(busy), 64'd0);
    checkEq("rst done", 64'(done), 64'd0);
    checkEq("rst txd bc1", 64'(uart_txd1), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("post-rst txd", 64'(uart_txd), 64'd1);
    checkEq("post-rst in_ready", 64'(in_ready), 64'd1);
    checkEq("post-rst busy", 64'(busy), 64'd0);
    checkEq("post-rst done", 64'(done), 64'd0);

    // Single word.
    offerWord(1'b0, 32'h0000_5000, 32'h0000_0001, "single");
    in_valid = 1'b0;
    checkFrame(1'b0, 2, 80'hAA_00_50_00_00_01_00_00_00_55, "single", 1'b0);
    @(negedge clk);
    checkEq("single done once", 64'(done), 64'd0);
    checkEq("single idle busy", 64'(busy), 64'd0);

    // Back-to-back: in_valid held, second word presented right after the first
    // is accepted, taken in the done cycle.
    offerWord(1'b0, 32'h0000_4002, 32'h1800_0040, "b2b first");
    in_address = 32'h0000_4003;
    in_data    = 32'h0001_0003;
    checkFrame(1'b0, 2, 80'hAA_02_40_00_00_40_00_00_18_55, "b2b first", 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkFrame(1'b0, 2, 80'hAA_03_40_00_00_03_00_01_00_55, "b2b second", 1'b0);
    @(negedge clk);
    checkEq("b2b done twice only", 64'(done), 64'd0);

    // Input stability: inputs and in_valid change every cycle mid-frame.
    offerWord(1'b0, 32'h1234_5678, 32'hCAFE_F00D, "stable");
    in_valid = 1'b0;
    checkFrame(1'b0, 2, 80'hAA_78_56_34_12_0D_F0_FE_CA_55, "stable", 1'b1);
    @(negedge clk);
    checkEq("stable no extra accept", 64'(busy), 64'd0);

    // Reset during byte 4 (0xF7), bit 3 (a zero bit): cycle 89 after accept.
    offerWord(1'b0, 32'hF700_0000, 32'h0000_0000, "midrst");
    in_valid = 1'b0;
    repeat (89) @(negedge clk);
    checkEq("midrst line low before", 64'(uart_txd), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("midrst async txd", 64'(uart_txd), 64'd1);
    checkEq("midrst async busy", 64'(busy), 64'd0);
    checkEq("midrst async in_ready", 64'(in_ready), 64'd1);
    doneSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) doneSeen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) doneSeen = 1'b1;
    checkEq("midrst no done", 64'(doneSeen), 64'd0);
    checkEq("midrst ready after", 64'(in_ready), 64'd1);
    offerWord(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, "after rst");
    in_valid = 1'b0;
    checkFrame(1'b0, 2, 80'hAA_00_00_00_00_FF_FF_FF_FF_55, "after rst", 1'b0);

    // One clock per bit: frame is 100 cycles.
    @(negedge clk);
    offerWord(1'b1, 32'h0000_5000, 32'h0000_0001, "bc1");
    in_valid1 = 1'b0;
    checkFrame(1'b1, 1, 80'hAA_00_50_00_00_01_00_00_00_55, "bc1", 1'b0);
    @(negedge clk);
    checkEq("bc1 done once", 64'(done1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
